// File: rtl/rst_run_pkg.sv
// Shared types and constants for the staged reset / run-length controller.
package rst_run_pkg;

  typedef enum logic [1:0] {
    RrHold,
    RrRelease,
    RrRun,
    RrDone
  } rst_run_state_e;

  typedef logic [7:0] exit_code_t;

  localparam exit_code_t ExitTimeout = 8'hFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_run_delay.sv
// Loadable down-counter with a zero flag; used for the initial hold and the release gaps.
// Load wins over decrement; the counter parks at zero until it is reloaded.
module rst_run_delay #(
  parameter int              Width  = 3,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RstVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_run_ctrl.sv
// Staged reset release, run-cycle budget and halt/exit-code capture for the demo system.
// All outputs registered; halt_req_i is a level sampled only while running.
module rst_run_ctrl
  import rst_run_pkg::*;
#(
  parameter int unsigned NumResets  = 2,
  parameter int unsigned InitHold   = 2,
  parameter int unsigned ReleaseGap = 4,
  parameter int unsigned MaxCycles  = 100000,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic                 halt_req_i,
  input  logic [7:0]           halt_code_i,
  output logic                 halt_ack_o,
  output logic [NumResets-1:0] rst_n_o,
  output logic [CntWidth-1:0]  cycle_cnt_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [7:0]           exit_code_o
);

  localparam int unsigned DlyW = $clog2(max_int(int'(InitHold), int'(ReleaseGap)) + 1);
  localparam logic [DlyW-1:0]      HoldLoad  = DlyW'(InitHold - 1);
  localparam logic [DlyW-1:0]      GapLoad   = DlyW'(ReleaseGap - 1);
  localparam logic [NumResets-1:0] AllRel    = {NumResets{1'b1}};
  localparam logic [NumResets-1:0] Bit0      = NumResets'(1);
  localparam logic [CntWidth-1:0]  CntMax    = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0]  LastCnt   = CntWidth'(MaxCycles - 1);
  localparam logic [CntWidth-1:0]  BudgetCnt = CntWidth'(MaxCycles);
  localparam logic                 TimeoutEn = (MaxCycles != 0);

  rst_run_state_e state_q, state_d;

  logic [NumResets-1:0] rst_n_q, rst_n_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 ack_q, ack_d;
  exit_code_t           exit_q, exit_d;

  logic                 dly_load;
  logic [DlyW-1:0]      dly_load_val;
  logic                 dly_zero;

  logic budget_end;
  assign budget_end = TimeoutEn && (cnt_q == LastCnt);

  rst_run_delay #(
    .Width  (DlyW),
    .RstVal (HoldLoad)
  ) u_delay (
    .clk_i      (clk_sys_i),
    .rst_i      (rst_sys_i),
    .load_i     (dly_load),
    .load_val_i (dly_load_val),
    .zero_o     (dly_zero)
  );

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q <= RrHold;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RrHold:    if (dly_zero) state_d = RrRelease;
      RrRelease: if (rst_n_q == AllRel) state_d = RrRun;
      RrRun:     if (halt_req_i || budget_end) state_d = RrDone;
      RrDone:    state_d = RrDone;
      default:   state_d = RrHold;
    endcase
  end

  always_comb begin
    rst_n_d      = rst_n_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    exit_d       = exit_q;
    ack_d        = 1'b0;
    dly_load     = 1'b0;
    dly_load_val = GapLoad;
    running_d    = (state_d == RrRun);
    done_d       = (state_d == RrDone);
    unique case (state_q)
      RrHold: begin
        if (dly_zero) begin
          rst_n_d  = rst_n_q | Bit0;
          dly_load = 1'b1;
        end
      end
      RrRelease: begin
        // Thermometer release: each gap expiry shifts in one more high bit.
        if (rst_n_q != AllRel && dly_zero) begin
          rst_n_d  = (rst_n_q << 1) | Bit0;
          dly_load = 1'b1;
        end
      end
      RrRun: begin
        if (halt_req_i) begin
          ack_d  = 1'b1;
          exit_d = halt_code_i;
        end else if (budget_end) begin
          cnt_d     = BudgetCnt;
          timeout_d = 1'b1;
          exit_d    = ExitTimeout;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      rst_n_q   <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      exit_q    <= '0;
    end else begin
      rst_n_q   <= rst_n_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      exit_q    <= exit_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign cycle_cnt_o = cnt_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign halt_ack_o  = ack_q;
  assign exit_code_o = exit_q;

endmodule

// File: tb/tb_rst_run_ctrl.sv
// Bench for rst_run_ctrl: two instances (2 domains / budget 16, and 3 domains / no budget / 4-bit counter).
module tb_rst_run_ctrl;

  localparam int IH  = 2;
  localparam int GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, halt_a = 1'b0;
  logic [7:0] code_a = 8'h00;
  logic       ack_a, running_a, done_a, to_a;
  logic [1:0] rst_n_a;
  logic [31:0] cnt_a;
  logic [7:0] exit_a;

  logic       rst_b = 1'b1, halt_b = 1'b0;
  logic [7:0] code_b = 8'h00;
  logic       ack_b, running_b, done_b, to_b;
  logic [2:0] rst_n_b;
  logic [3:0] cnt_b;
  logic [7:0] exit_b;

  rst_run_ctrl #(.NumResets(2), .InitHold(IH), .ReleaseGap(GAP), .MaxCycles(16), .CntWidth(32)) u_dut_a (
    .clk_sys_i(clk), .rst_sys_i(rst_a), .halt_req_i(halt_a), .halt_code_i(code_a),
    .halt_ack_o(ack_a), .rst_n_o(rst_n_a), .cycle_cnt_o(cnt_a), .running_o(running_a),
    .done_o(done_a), .timeout_o(to_a), .exit_code_o(exit_a));

  rst_run_ctrl #(.NumResets(3), .InitHold(IH), .ReleaseGap(GAP), .MaxCycles(0), .CntWidth(4)) u_dut_b (
    .clk_sys_i(clk), .rst_sys_i(rst_b), .halt_req_i(halt_b), .halt_code_i(code_b),
    .halt_ack_o(ack_b), .rst_n_o(rst_n_b), .cycle_cnt_o(cnt_b), .running_o(running_b),
    .done_o(done_b), .timeout_o(to_b), .exit_code_o(exit_b));

  wire [45:0] obs_a = {rst_n_a, running_a, done_a, to_a, ack_a, exit_a, cnt_a};
  wire [18:0] obs_b = {rst_n_b, running_b, done_b, to_b, ack_b, exit_b, cnt_b};

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: edges since reset release plus the run outcome.
  int         m_e    [2] = '{0, 0};
  logic       m_done [2] = '{1'b0, 1'b0};
  logic       m_to   [2] = '{1'b0, 1'b0};
  logic       m_ack  [2] = '{1'b0, 1'b0};
  logic [7:0] m_code [2] = '{8'h00, 8'h00};
  longint     m_cnt  [2] = '{0, 0};

  function automatic int n_dom(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int run_start(input int d);
    return IH + (n_dom(d) - 1) * GAP + 1;
  endfunction

  function automatic logic run_m(input int d);
    return (m_e[d] >= run_start(d)) && !m_done[d];
  endfunction

  task automatic model_step(input int d, input logic r, input logic h, input logic [7:0] c);
    longint budget = (d == 0) ? 16 : 0;
    longint cmax   = (d == 0) ? 64'hFFFF_FFFF : 15;
    if (r) begin
      m_e[d] = 0; m_done[d] = 0; m_to[d] = 0; m_ack[d] = 0; m_code[d] = 0; m_cnt[d] = 0;
      return;
    end
    m_ack[d] = 1'b0;
    if (run_m(d)) begin
      if (h) begin
        m_done[d] = 1'b1; m_ack[d] = 1'b1; m_code[d] = c;
      end else if (budget != 0 && m_cnt[d] == budget - 1) begin
        m_cnt[d] = budget; m_done[d] = 1'b1; m_to[d] = 1'b1; m_code[d] = 8'hFF;
      end else if (m_cnt[d] < cmax) begin
        m_cnt[d]++;
      end
    end
    m_e[d]++;
  endtask

  function automatic logic [45:0] exp_a();
    logic [1:0] r;
    longint     c = m_cnt[0];
    for (int k = 0; k < 2; k++) r[k] = (m_e[0] >= IH + k * GAP);
    return {r, run_m(0), m_done[0], m_to[0], m_ack[0], m_code[0], c[31:0]};
  endfunction

  function automatic logic [18:0] exp_b();
    logic [2:0] r;
    longint     c = m_cnt[1];
    for (int k = 0; k < 3; k++) r[k] = (m_e[1] >= IH + k * GAP);
    return {r, run_m(1), m_done[1], m_to[1], m_ack[1], m_code[1], c[3:0]};
  endfunction

  // One clock: model consumes the inputs the DUTs sampled; outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    model_step(0, rst_a, halt_a, code_a);
    model_step(1, rst_b, halt_b, code_b);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; halt_a = 1'b1; halt_b = 1'b1;
    code_a = 8'($urandom); code_b = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL reset c%0d got %h want %h", i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
    end
    n_cmp++;
    if ({rst_n_a, cnt_a, running_a, done_a, ack_a} !== 37'd0) begin
      n_err++; $display("FAIL reset_a_zero got %b/%0d want 00/0", rst_n_a, cnt_a);
    end
    halt_a = 1'b0; halt_b = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_release_timeout();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int e = 1; e <= 73; e++) begin
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL release_timeout e%0d got %h want %h", e, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
      if (e == 1 || e == 2 || e == 6 || e == 7 || e == 23) begin
        logic [1:0] want_rst = (e == 1) ? 2'b00 : (e == 2) ? 2'b01 : 2'b11;
        n_cmp++;
        if (rst_n_a !== want_rst || running_a !== (e == 7) || (e == 7 && cnt_a !== 0)) begin
          n_err++; $display("FAIL release_edge e%0d got rst_n=%b run=%b cnt=%0d want rst_n=%b", e, rst_n_a, running_a, cnt_a, want_rst);
        end
      end
    end
    n_cmp++;
    if (done_a !== 1'b1 || to_a !== 1'b1 || exit_a !== 8'hFF || cnt_a !== 32'd16) begin
      n_err++; $display("FAIL timeout_final got done=%b to=%b code=%h cnt=%0d want 1/1/ff/16", done_a, to_a, exit_a, cnt_a);
    end
  endtask

  task automatic test_halt(input string name, input int at_cnt, input logic [7:0] code);
    int acks = 0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      halt_a = run_m(0) && (m_cnt[0] == at_cnt);
      code_a = halt_a ? code : 8'($urandom);
      tick();
      acks += int'(ack_a);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL %s c%0d got %h want %h", name, i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
    end
    halt_a = 1'b0;
    n_cmp++;
    if (acks !== 1 || exit_a !== code || cnt_a !== 32'(at_cnt) || to_a !== 1'b0 || done_a !== 1'b1) begin
      n_err++; $display("FAIL %s_final got acks=%0d code=%h cnt=%0d to=%b want 1/%h/%0d/0", name, acks, exit_a, cnt_a, to_a, code, at_cnt);
    end
  endtask

  task automatic test_early_halt();
    int acks = 0;
    logic [7:0] code = 8'($urandom);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    halt_a = 1'b1; code_a = code;
    for (int i = 0; i < 40; i++) begin
      if (i >= 12) begin
        halt_a = 1'($urandom); code_a = 8'($urandom);
      end
      tick();
      acks += int'(ack_a);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL early_halt c%0d got %h want %h", i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
    end
    halt_a = 1'b0;
    n_cmp++;
    if (acks !== 1 || cnt_a !== 32'd0 || exit_a !== code) begin
      n_err++; $display("FAIL early_halt_final got acks=%0d cnt=%0d code=%h want 1/0/%h", acks, cnt_a, exit_a, code);
    end
  endtask

  task automatic test_reset_midrun();
    logic hit = 1'b0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rst_a = !hit && run_m(0) && (m_cnt[0] == 9);
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL reset_midrun c%0d got %h want %h", i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
      if (rst_a) begin
        hit = 1'b1;
        n_cmp++;
        if (rst_n_a !== 2'b00 || cnt_a !== 32'd0) begin
          n_err++; $display("FAIL reset_midrun_drop got rst_n=%b cnt=%0d want 00/0", rst_n_a, cnt_a);
        end
      end
    end
    rst_a = 1'b0;
    n_cmp++;
    if (!hit || done_a !== 1'b1 || to_a !== 1'b1 || cnt_a !== 32'd16) begin
      n_err++; $display("FAIL reset_midrun_final got hit=%b done=%b to=%b cnt=%0d want 1/1/1/16", hit, done_a, to_a, cnt_a);
    end
  endtask

  task automatic test_saturate();
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int i = 0; i < 50; i++) begin
      halt_b = (m_e[1] < run_start(1) - 1) ? 1'($urandom) : 1'b0;
      code_b = 8'($urandom);
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL saturate c%0d got %h want %h", i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
    end
    n_cmp++;
    if (cnt_b !== 4'hF || running_b !== 1'b1 || done_b !== 1'b0 || rst_n_b !== 3'b111) begin
      n_err++; $display("FAIL saturate_final got cnt=%h run=%b done=%b rst_n=%b want f/1/0/111", cnt_b, running_b, done_b, rst_n_b);
    end
    halt_b = 1'b1; code_b = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      tick();
      halt_b = 1'b0;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_err++; $display("FAIL saturate_halt c%0d got %h want %h", i, {obs_a, obs_b}, {exp_a(), exp_b()});
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      rst_a = 1'b1; rst_b = 1'b1; tick(); rst_a = 1'b0; rst_b = 1'b0;
      for (int i = 0; i < 80; i++) begin
        halt_a = ($urandom_range(15) == 0);
        halt_b = ($urandom_range(20) == 0);
        code_a = 8'($urandom); code_b = 8'($urandom);
        rst_a  = ($urandom_range(63) == 0);
        rst_b  = ($urandom_range(63) == 0);
        tick();
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
          n_err++; $display("FAIL random r%0d c%0d got %h want %h", r, i, {obs_a, obs_b}, {exp_a(), exp_b()});
        end
      end
    end
    rst_a = 1'b0; rst_b = 1'b0; halt_a = 1'b0; halt_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_release_timeout();
    test_halt("halt", 4, 8'h2A);
    test_halt("halt_last", 15, 8'h01);
    test_early_halt();
    test_reset_midrun();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
